// File: rtl/k10_pmp_csr_if.sv
// k10_pmp_csr_if: CSR request/response bus between the CSR unit and the
// PMP register file. Also carries the privilege-level package.
//   master : CSR unit (drives i_req_*, receives o_req_ready and o_rsp_*)
//   slave  : k10_pmp_csr
package k10_pmp_pkg;
  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_e;
endpackage

interface k10_pmp_csr_if;
  import k10_pmp_pkg::*;

  logic        i_req_valid;
  logic        o_req_ready;
  logic [11:0] i_req_addr;
  logic        i_req_we;
  logic [31:0] i_req_wdata;
  priv_lvl_e   i_req_priv;
  logic        o_rsp_valid;
  logic        o_rsp_hit;
  logic        o_rsp_err;
  logic [31:0] o_rsp_rdata;

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_priv,
    input  o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_err, o_rsp_rdata
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_priv,
    output o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_err, o_rsp_rdata
  );
endinterface

// File: rtl/k10_pmp_csr.sv
// k10_pmp_csr: PMP register file (pmpcfg0..3, pmpaddr0..15).
// Services one CSR access per two cycles: accept in IDLE, respond in RESP.
// Writes commit on the accept edge; the response returns the pre-write value.
// Applies WARL legalisation of cfg bytes, entry lock, and TOR lock of the
// preceding address register.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : CSR request/response (k10_pmp_csr_if.slave)
//   o_pmp_cfg      : per-entry config bytes for the PMP checkers
//   o_pmp_addr     : per-entry addresses for the PMP checkers
//   o_pmp_flush    : (K10_PMP_FLUSH_EN only) pulses in RESP when a write
//                    changed any stored cfg/addr bit
//
// Optional feature macro: K10_PMP_FLUSH_EN
module k10_pmp_csr
  import k10_pmp_pkg::*;
#(
  parameter int PMP_REGIONS = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  k10_pmp_csr_if.slave                 bus,
  output logic [PMP_REGIONS-1:0][7:0]  o_pmp_cfg,
  output logic [PMP_REGIONS-1:0][31:0] o_pmp_addr
`ifdef K10_PMP_FLUSH_EN
  ,
  output logic                         o_pmp_flush
`endif
);

  if (!(PMP_REGIONS == 4 || PMP_REGIONS == 8 ||
        PMP_REGIONS == 12 || PMP_REGIONS == 16)) begin : g_bad_regions
    $error("k10_pmp_csr: PMP_REGIONS must be 4, 8, 12 or 16");
  end

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e state_q, state_d;

  logic [PMP_REGIONS-1:0][7:0]  cfg_q,  cfg_d;
  logic [PMP_REGIONS-1:0][31:0] addr_q, addr_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_hit_q,   rsp_hit_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic       accept;
  logic       is_cfg, is_addr, hit, priv_ok, err, wr_ok;
  logic [1:0] cfg_sel;
  logic [3:0] addr_sel;
  logic [31:0] rdata;

  assign accept   = bus.i_req_valid && (state_q == ST_IDLE);
  assign is_cfg   = (bus.i_req_addr[11:2] == 10'h0E8);  // 0x3A0..0x3A3
  assign is_addr  = (bus.i_req_addr[11:4] == 8'h3B);    // 0x3B0..0x3BF
  assign cfg_sel  = bus.i_req_addr[1:0];
  assign addr_sel = bus.i_req_addr[3:0];
  assign hit      = is_cfg || is_addr;
  assign priv_ok  = (bus.i_req_priv == PRIV_M);
  assign err      = hit && !priv_ok;
  assign wr_ok    = accept && bus.i_req_we && hit && priv_ok;

  // Unimplemented entries simply never match the loop index, so they read 0.
  always_comb begin
    rdata = '0;
    if (hit && priv_ok) begin
      if (is_cfg) begin
        for (int e = 0; e < PMP_REGIONS; e++) begin
          if ((e / 4) == int'(cfg_sel)) rdata[8*(e%4) +: 8] = cfg_q[e];
        end
      end else begin
        for (int e = 0; e < PMP_REGIONS; e++) begin
          if (e == int'(addr_sel)) rdata = addr_q[e];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-entry write legalisation. Lock checks read cfg_q, i.e. the state
  // before this write, so a cfg write and an addr write never interact.
  // ---------------------------------------------------------------------
  for (genvar e = 0; e < PMP_REGIONS; e++) begin : g_ent
    localparam logic [1:0] CFG_SEL  = 2'(e / 4);
    localparam logic [3:0] ADDR_SEL = 4'(e);

    logic [7:0] wbyte, wbyte_legal;
    logic       tor_lock, cfg_we, addr_we;

    assign wbyte = bus.i_req_wdata[8*(e%4) +: 8];
    // [6:5] are reserved-zero; R=0/W=1 is reserved, so W is dropped.
    assign wbyte_legal = {wbyte[7], 2'b00, wbyte[4:2],
                          wbyte[1] & wbyte[0], wbyte[0]};

    // A locked TOR entry above also freezes this entry's address (its base).
    if (e + 1 < PMP_REGIONS) begin : g_tor
      assign tor_lock = cfg_q[e+1][7] && (cfg_q[e+1][4:3] == 2'b01);
    end else begin : g_no_tor
      assign tor_lock = 1'b0;
    end

    assign cfg_we  = wr_ok && is_cfg && (cfg_sel == CFG_SEL) && !cfg_q[e][7];
    assign addr_we = wr_ok && is_addr && (addr_sel == ADDR_SEL) &&
                     !cfg_q[e][7] && !tor_lock;

    assign cfg_d[e]  = cfg_we  ? wbyte_legal     : cfg_q[e];
    assign addr_d[e] = addr_we ? bus.i_req_wdata : addr_q[e];
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    rsp_valid_d     = 1'b0;
    rsp_hit_d       = 1'b0;
    rsp_err_d       = 1'b0;
    rsp_rdata_d     = '0;
    bus.o_req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = hit;
          rsp_err_d   = err;
          rsp_rdata_d = rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_hit   = rsp_hit_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign o_pmp_cfg       = cfg_q;
  assign o_pmp_addr      = addr_q;

`ifdef K10_PMP_FLUSH_EN
  // Next state only differs from current on an accepted, effective write,
  // so ignored or identical writes never raise a flush.
  logic flush_q, flush_d;

  always_comb begin
    flush_d = (cfg_d != cfg_q) || (addr_d != addr_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) flush_q <= 1'b0;
    else          flush_q <= flush_d;
  end

  assign o_pmp_flush = flush_q;
`endif

endmodule

// File: tb/tb_k10_pmp_csr.sv
// tb_k10_pmp_csr: table-driven check of k10_pmp_csr (PMP_REGIONS = 16)
// plus hand sequences for reset state, response pulse shape and reset in RESP.
module tb_k10_pmp_csr;
  import k10_pmp_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [15:0][7:0]  o_pmp_cfg;
  logic [15:0][31:0] o_pmp_addr;
`ifdef K10_PMP_FLUSH_EN
  logic o_pmp_flush;
`endif

  k10_pmp_csr_if bus ();

  k10_pmp_csr #(.PMP_REGIONS(16)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .bus        (bus),
    .o_pmp_cfg  (o_pmp_cfg),
    .o_pmp_addr (o_pmp_addr)
`ifdef K10_PMP_FLUSH_EN
    ,
    .o_pmp_flush(o_pmp_flush)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    priv_lvl_e   priv;
    logic        hit;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  idx;    // entry whose cfg/addr is checked after the access
    logic [7:0]  cfg;
    logic [31:0] addrv;
    logic        flush;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one access; returns at the negedge inside the RESP cycle.
  task automatic access(input logic [11:0] a, input logic we,
                        input logic [31:0] wd, input priv_lvl_e p);
    int t;
    t = 0;
    @(negedge i_clk);
    chk("idle_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    bus.i_req_addr  = a;
    bus.i_req_we    = we;
    bus.i_req_wdata = wd;
    bus.i_req_priv  = p;
    bus.i_req_valid = 1'b1;
    while (!bus.o_req_ready && t < 10) begin
      @(negedge i_clk);
      t++;
    end
    if (!bus.o_req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: ready stuck at 0 for addr %03h", a);
    end
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("resp_valid", {31'b0, bus.o_rsp_valid}, 32'd1);
    chk("resp_ready", {31'b0, bus.o_req_ready}, 32'd0);
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_we    = 1'b0;
    bus.i_req_wdata = '0;
    bus.i_req_priv  = PRIV_M;

    //         addr    we  wdata          priv    hit err rdata         idx cfg    addr          flush
    vq.push_back('{12'h3A0, 0, 32'h0,         PRIV_M, 1, 0, 32'h0,        0, 8'h00, 32'h0,        0});
    vq.push_back('{12'h3B5, 0, 32'h0,         PRIV_M, 1, 0, 32'h0,        5, 8'h00, 32'h0,        0});
    vq.push_back('{12'h3B0, 1, 32'h2000_03FF, PRIV_M, 1, 0, 32'h0,        0, 8'h00, 32'h2000_03FF, 1});
    vq.push_back('{12'h3A0, 1, 32'h0000_001F, PRIV_M, 1, 0, 32'h0,        0, 8'h1F, 32'h2000_03FF, 1});
    vq.push_back('{12'h3A0, 0, 32'h0,         PRIV_M, 1, 0, 32'h0000_001F, 0, 8'h1F, 32'h2000_03FF, 0});
    // byte0 0x02 (R=0,W=1) -> 0x00; byte1 0x9E also has R=0,W=1 -> 0x9C
    vq.push_back('{12'h3A0, 1, 32'h0000_9E02, PRIV_M, 1, 0, 32'h0000_001F, 1, 8'h9C, 32'h0,        1});
    vq.push_back('{12'h3A0, 0, 32'h0,         PRIV_M, 1, 0, 32'h0000_9C00, 0, 8'h00, 32'h2000_03FF, 0});
    // entry 1 locked: its byte survives a zero write; nothing else changes
    vq.push_back('{12'h3A0, 1, 32'h0,         PRIV_M, 1, 0, 32'h0000_9C00, 1, 8'h9C, 32'h0,        0});
    vq.push_back('{12'h3B1, 1, 32'h0000_1234, PRIV_M, 1, 0, 32'h0,        1, 8'h9C, 32'h0,        0});
    // entry 3 = L|TOR|R (0x89): freezes addr[2] and addr[3]
    vq.push_back('{12'h3A0, 1, 32'h8900_0000, PRIV_M, 1, 0, 32'h0000_9C00, 3, 8'h89, 32'h0,        1});
    vq.push_back('{12'h3B2, 1, 32'h0000_0055, PRIV_M, 1, 0, 32'h0,        2, 8'h00, 32'h0,        0});
    vq.push_back('{12'h3B3, 1, 32'h0000_0077, PRIV_M, 1, 0, 32'h0,        3, 8'h89, 32'h0,        0});
    vq.push_back('{12'h3B4, 1, 32'hFFFF_FFFF, PRIV_U, 1, 1, 32'h0,        4, 8'h00, 32'h0,        0});
    vq.push_back('{12'h3B0, 0, 32'h0,         PRIV_U, 1, 1, 32'h0,        0, 8'h00, 32'h2000_03FF, 0});
    vq.push_back('{12'h3A0, 0, 32'h0,         PRIV_S, 1, 1, 32'h0,        3, 8'h89, 32'h0,        0});
    vq.push_back('{12'h3C0, 0, 32'h0,         PRIV_M, 0, 0, 32'h0,        0, 8'h00, 32'h2000_03FF, 0});
    vq.push_back('{12'h3C0, 1, 32'hFFFF_FFFF, PRIV_U, 0, 0, 32'h0,        0, 8'h00, 32'h2000_03FF, 0});
    // entry 1 is locked but NAPOT, so addr[0] stays writable
    vq.push_back('{12'h3B0, 1, 32'h0000_0055, PRIV_M, 1, 0, 32'h2000_03FF, 0, 8'h00, 32'h0000_0055, 1});
    vq.push_back('{12'h3B4, 1, 32'hDEAD_BEEF, PRIV_M, 1, 0, 32'h0,        4, 8'h00, 32'hDEAD_BEEF, 1});
    vq.push_back('{12'h3B4, 0, 32'h0,         PRIV_M, 1, 0, 32'hDEAD_BEEF, 4, 8'h00, 32'hDEAD_BEEF, 0});
    vq.push_back('{12'h3B5, 1, 32'h0000_0011, PRIV_M, 1, 0, 32'h0,        5, 8'h00, 32'h0000_0011, 1});
    vq.push_back('{12'h3B5, 1, 32'h0000_0011, PRIV_M, 1, 0, 32'h0000_0011, 5, 8'h00, 32'h0000_0011, 0});
    vq.push_back('{12'h3B3, 1, 32'h0000_0099, PRIV_M, 1, 0, 32'h0,        3, 8'h89, 32'h0,        0});

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready",     {31'b0, bus.o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    chk("rst_rsp_hit",   {31'b0, bus.o_rsp_hit},   32'd0);
    chk("rst_rsp_err",   {31'b0, bus.o_rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus.o_rsp_rdata,          32'd0);
    chk("rst_cfg_any",   {31'b0, |o_pmp_cfg},      32'd0);
    chk("rst_addr_any",  {31'b0, |o_pmp_addr},     32'd0);
    i_rst_n = 1'b1;

    foreach (vq[i]) begin
      access(vq[i].addr, vq[i].we, vq[i].wdata, vq[i].priv);
      chk($sformatf("v%0d_hit", i),   {31'b0, bus.o_rsp_hit}, {31'b0, vq[i].hit});
      chk($sformatf("v%0d_err", i),   {31'b0, bus.o_rsp_err}, {31'b0, vq[i].err});
      chk($sformatf("v%0d_rdata", i), bus.o_rsp_rdata,        vq[i].rdata);
      chk($sformatf("v%0d_cfg%0d", i, vq[i].idx),  {24'b0, o_pmp_cfg[vq[i].idx]}, {24'b0, vq[i].cfg});
      chk($sformatf("v%0d_addr%0d", i, vq[i].idx), o_pmp_addr[vq[i].idx],         vq[i].addrv);
`ifdef K10_PMP_FLUSH_EN
      chk($sformatf("v%0d_flush", i), {31'b0, o_pmp_flush}, {31'b0, vq[i].flush});
`endif
    end

    // Reset asserted in the middle of RESP: outputs clear at once.
    access(12'h3B6, 1'b1, 32'h0000_ABCD, PRIV_M);
    chk("rr_addr6_pre", o_pmp_addr[6], 32'h0000_ABCD);
    chk("rr_hit_pre",   {31'b0, bus.o_rsp_hit}, 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rr_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    chk("rr_rsp_hit",   {31'b0, bus.o_rsp_hit},   32'd0);
    chk("rr_ready",     {31'b0, bus.o_req_ready}, 32'd1);
    chk("rr_addr6",     o_pmp_addr[6],            32'd0);
    chk("rr_cfg1",      {24'b0, o_pmp_cfg[1]},    32'd0);
`ifdef K10_PMP_FLUSH_EN
    chk("rr_flush",     {31'b0, o_pmp_flush},     32'd0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Lock is gone after reset: entry 1 writable again.
    access(12'h3B1, 1'b1, 32'h0000_1234, PRIV_M);
    chk("post_rst_rdata", bus.o_rsp_rdata, 32'd0);
    chk("post_rst_addr1", o_pmp_addr[1],   32'h0000_1234);
    @(negedge i_clk);
    chk("post_rst_idle_valid", {31'b0, bus.o_rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
